// File: rtl/synap_pkg.sv
// Shared widths and FSM encoding for the synapse row scanner.
// Widths here are for the default configuration; modules re-derive them from their own parameters.
package synap_pkg;

  localparam int NUM_AXONS_DEF   = 256;
  localparam int NUM_NEURONS_DEF = 256;
  localparam int SCAN_WIDTH_DEF  = 16;

  localparam int AXON_W        = $clog2(NUM_AXONS_DEF);
  localparam int NEURON_W      = $clog2(NUM_NEURONS_DEF);
  localparam int WORDS_PER_ROW = NUM_NEURONS_DEF / SCAN_WIDTH_DEF;
  localparam int WORD_IDX_W    = $clog2(WORDS_PER_ROW);
  localparam int BIT_IDX_W     = $clog2(SCAN_WIDTH_DEF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/synap_prio_enc.sv
// Lowest-set-bit finder over one crossbar word.
module synap_prio_enc #(
  parameter int SCAN_WIDTH = 16
) (
  input  logic [SCAN_WIDTH-1:0]         vec_i,
  output logic [$clog2(SCAN_WIDTH)-1:0] idx_o,
  output logic                          any_o
);

  localparam int BW = $clog2(SCAN_WIDTH);

  // Walk from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx_o = '0;
    for (int i = SCAN_WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = BW'(i);
    end
    any_o = |vec_i;
  end

endmodule

// File: rtl/synap_row_scanner.sv
// Scans one axon's crossbar row a word at a time and streams connected neuron indices.
// Optional connection counter output enabled by defining SYNAP_CONN_COUNT_EN.
module synap_row_scanner
  import synap_pkg::*;
#(
  parameter int NUM_AXONS   = NUM_AXONS_DEF,
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int SCAN_WIDTH  = SCAN_WIDTH_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cfg_we,
  input  logic [$clog2(NUM_AXONS)-1:0]              cfg_axon,
  input  logic [$clog2(NUM_NEURONS/SCAN_WIDTH)-1:0] cfg_word,
  input  logic [SCAN_WIDTH-1:0]                     cfg_data,
  input  logic                                      start,
  input  logic [$clog2(NUM_AXONS)-1:0]              axon_number,
  output logic                                      busy,
  output logic [$clog2(NUM_NEURONS)-1:0]            neuron_number,
  output logic                                      neuron_valid,
  input  logic                                      neuron_ready,
  output logic                                      done
`ifdef SYNAP_CONN_COUNT_EN
  ,
  output logic [$clog2(NUM_NEURONS):0]              conn_count
`endif
);

  localparam int W   = NUM_NEURONS / SCAN_WIDTH;
  localparam int AW  = $clog2(NUM_AXONS);
  localparam int NW  = $clog2(NUM_NEURONS);
  localparam int WIW = $clog2(W);
  localparam int BW  = $clog2(SCAN_WIDTH);
  localparam logic [WIW-1:0] LAST_WORD = WIW'(W - 1);

  scan_state_e           state_q, state_d;
  logic [AW-1:0]         axon_q, axon_d;
  logic [WIW-1:0]        word_idx_q, word_idx_d;
  logic [SCAN_WIDTH-1:0] mask_q, mask_d;
  logic [NW-1:0]         nn_q, nn_d;
  logic                  nv_q, nv_d;

  logic [SCAN_WIDTH-1:0] mem [NUM_AXONS*W];
  logic [SCAN_WIDTH-1:0] rd_word;
  logic [BW-1:0]         bit_idx;
  logic                  any_set;
  logic                  can_load;
  logic                  hs;

  // Crossbar contents survive reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE) mem[{cfg_axon, cfg_word}] <= cfg_data;
  end

  assign rd_word = mem[{axon_q, word_idx_q}];

  synap_prio_enc #(.SCAN_WIDTH(SCAN_WIDTH)) u_penc (
    .vec_i (mask_q),
    .idx_o (bit_idx),
    .any_o (any_set)
  );

  assign hs       = nv_q & neuron_ready;
  assign can_load = ~nv_q | neuron_ready;

  always_comb begin
    state_d    = state_q;
    axon_d     = axon_q;
    word_idx_d = word_idx_q;
    mask_d     = mask_q;
    nn_d       = nn_q;
    nv_d       = nv_q & ~neuron_ready;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          axon_d     = axon_number;
          word_idx_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        mask_d  = rd_word;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (any_set) begin
          if (can_load) begin
            nn_d   = {word_idx_q, bit_idx};
            nv_d   = 1'b1;
            mask_d = mask_q & ~(SCAN_WIDTH'(1) << bit_idx);
          end
        end else if (word_idx_q != LAST_WORD) begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = S_FETCH;
        end else if (can_load) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        nv_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      axon_q     <= '0;
      word_idx_q <= '0;
      mask_q     <= '0;
      nn_q       <= '0;
      nv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      axon_q     <= axon_d;
      word_idx_q <= word_idx_d;
      mask_q     <= mask_d;
      nn_q       <= nn_d;
      nv_q       <= nv_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign neuron_number = nn_q;
  assign neuron_valid  = nv_q;

`ifdef SYNAP_CONN_COUNT_EN
  logic [NW:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && start) cnt_d = '0;
    else if (hs)                    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conn_count = cnt_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_synap_row_scanner.sv
// Randomised bench for synap_row_scanner against a row-of-bits reference model.
module tb_synap_row_scanner;

  localparam int NA = 256;
  localparam int NN = 256;
  localparam int SW = 16;
  localparam int W  = NN / SW;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [7:0]  cfg_axon;
  logic [3:0]  cfg_word;
  logic [15:0] cfg_data;
  logic        start;
  logic [7:0]  axon_number;
  logic        busy;
  logic [7:0]  neuron_number;
  logic        neuron_valid;
  logic        neuron_ready;
  logic        done;
`ifdef SYNAP_CONN_COUNT_EN
  logic [8:0]  conn_count;
`endif

  synap_row_scanner dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_axon      (cfg_axon),
    .cfg_word      (cfg_word),
    .cfg_data      (cfg_data),
    .start         (start),
    .axon_number   (axon_number),
    .busy          (busy),
    .neuron_number (neuron_number),
    .neuron_valid  (neuron_valid),
    .neuron_ready  (neuron_ready),
    .done          (done)
`ifdef SYNAP_CONN_COUNT_EN
    ,
    .conn_count    (conn_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference crossbar: one flat bit vector per axon, bit n = neuron n.
  logic [NN-1:0] ref_row [NA];

  task automatic write_row(input int ax, input logic [NN-1:0] row);
    for (int w = 0; w < W; w++) begin
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_axon = 8'(ax);
      cfg_word = 4'(w);
      cfg_data = row[w*SW +: SW];
      @(negedge clk);
      cfg_we   = 1'b0;
    end
    ref_row[ax] = row;
  endtask

  // rmode 0: ready always high; 1: random ready; 2: stall 5 cycles on neuron 17.
  task automatic run_scan(input int ax, input int rmode, input bit inject);
    int            exp_q[$];
    int            exp_done;
    int            cycle;
    int            hs;
    int            stall_cnt;
    bit            seen_done;
    bit            prev_stall;
    logic [7:0]    prev_nn;
    logic [NN-1:0] row;
    row = ref_row[ax];
    for (int n = 0; n < NN; n++) if (row[n]) exp_q.push_back(n);
    // With ready held high every word costs fetch+scan plus one cycle per connection.
    exp_done = 1;
    for (int w = 0; w < W; w++) exp_done += 2 + $countones(row[w*SW +: SW]);
    cycle = 0; hs = 0; stall_cnt = 0; seen_done = 0; prev_stall = 0; prev_nn = '0;
    @(negedge clk);
    start        = 1'b1;
    axon_number  = 8'(ax);
    neuron_ready = 1'b1;
    while (!seen_done && cycle < 3000) begin
      @(negedge clk);
      cycle++;
      start  = 1'b0;
      cfg_we = 1'b0;
      if (prev_stall) begin
        chk("hold_valid", neuron_valid, 1);
        chk("hold_nn", neuron_number, prev_nn);
      end
      if (done) begin
        seen_done = 1;
        chk("done_all_emitted", exp_q.size(), 0);
        chk("done_valid_low", neuron_valid, 0);
        if (rmode == 0) chk("done_cycle", cycle, exp_done);
`ifdef SYNAP_CONN_COUNT_EN
        chk("conn_count", conn_count, hs);
`endif
      end else begin
        chk("busy_in_scan", busy, 1);
      end
      case (rmode)
        0: neuron_ready = 1'b1;
        1: neuron_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (neuron_valid && neuron_number == 8'd17 && stall_cnt < 5) begin
            neuron_ready = 1'b0;
            stall_cnt++;
          end else neuron_ready = 1'b1;
        end
      endcase
      if (neuron_valid && neuron_ready) begin
        hs++;
        if (exp_q.size() == 0) chk("extra_idx", neuron_number, -1);
        else chk("idx", neuron_number, exp_q.pop_front());
      end
      prev_stall = neuron_valid && !neuron_ready;
      prev_nn    = neuron_number;
      if (inject && cycle == 6) begin
        start       = 1'b1;
        axon_number = 8'(ax ^ 1);
        cfg_we      = 1'b1;
        cfg_axon    = 8'(ax);
        cfg_word    = 4'd0;
        cfg_data    = ~row[SW-1:0];
      end
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    if (!seen_done) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    logic [NN-1:0] r;
    int            k;
    rst = 1'b1; cfg_we = 1'b0; cfg_axon = '0; cfg_word = '0; cfg_data = '0;
    start = 1'b0; axon_number = '0; neuron_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", neuron_valid, 0);
    chk("rst_nn", neuron_number, 0);
    chk("rst_done", done, 0);
`ifdef SYNAP_CONN_COUNT_EN
    chk("rst_count", conn_count, 0);
`endif
    rst = 1'b0;

    r = '0;
    write_row(5, r);
    r = '0; r[0] = 1'b1; r[1] = 1'b1; r[17] = 1'b1; r[255] = 1'b1;
    write_row(3, r);
    r = '1;
    write_row(0, r);
    for (int a = 10; a < 14; a++) begin
      for (int w = 0; w < NN/32; w++) r[w*32 +: 32] = $urandom & $urandom;
      for (int w = 0; w < W; w++) if ($urandom_range(0, 2) == 0) r[w*SW +: SW] = '0;
      write_row(a, r);
    end

    run_scan(5, 0, 0);
    run_scan(3, 0, 0);
    run_scan(3, 2, 0);
    run_scan(0, 0, 0);
    run_scan(3, 1, 1);
    run_scan(3, 0, 0);
    for (int a = 10; a < 14; a++) run_scan(a, int'($urandom_range(0, 1)), a == 11);
    run_scan(11, 0, 0);

    // Abort a scan with a pending output, then confirm the crossbar survived.
    @(negedge clk);
    start = 1'b1; axon_number = 8'd3; neuron_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!neuron_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_scan", neuron_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", neuron_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_nn", neuron_number, 0);
`ifdef SYNAP_CONN_COUNT_EN
    chk("abort_count", conn_count, 0);
`endif
    rst = 1'b0;
    run_scan(3, 0, 0);
    run_scan(12, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
